vga_pattern_gen: RTL

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pattern_sel.sv | 57 +++++
 rtl/vga_pattern_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator.
//   pattern_t      committed pattern encoding (matches the vga_state request code)
//   H/V_VISIBLE_DEF default active-area size
//   BAR_WIDTH      width of one colour bar in pixels
//   BLUE/WHITE/BLACK  packed {r[1:0], g[1:0], b[1:0]} colour constants
//   bar_index()    colour bar number for an x coordinate, wrapped to 0..7
package vga_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pattern_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int V_VISIBLE_DEF = 480;
    localparam int BAR_WIDTH     = 80;

    localparam logic [5:0] BLUE  = 6'b000011;
    localparam logic [5:0] WHITE = 6'b111111;
    localparam logic [5:0] BLACK = 6'b000000;

    // Coordinates past the last bar (scrolled or out-of-area x) repeat the
    // bar sequence, so only the low three bits of the quotient matter.
    function automatic logic [2:0] bar_index(input logic [9:0] x);
        return 3'(x / 10'(BAR_WIDTH));
    endfunction

endpackage

// File: rtl/vga_pattern_sel.sv
// Pattern commit FSM and frame counter.
// Ports:
//   clk         pixel clock, rising edge
//   rst         synchronous active-high reset
//   vga_state   requested pattern (sampled only on frame_done)
//   frame_done  one-cycle end-of-frame pulse
//   pattern     currently committed pattern
//   frame_cnt   frames since reset, wraps 255 -> 0
//
// state        | meaning
// -------------+-----------------------------------------------
// PAT_SOLID    | solid blue field (reset state)
// PAT_BARS     | eight vertical colour bars
// PAT_CHECKER  | 32x32 black/white checkerboard
// PAT_GRADIENT | colour ramps from x, y and frame count
module vga_pattern_sel
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] vga_state,
    input  logic       frame_done,
    output pattern_t   pattern,
    output logic [7:0] frame_cnt
);

    pattern_t state_q;
    pattern_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PAT_SOLID;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests are only honoured at a frame boundary so a pattern never
    // changes mid-frame; whatever is requested at the pulse wins.
    always_comb begin
        state_d = state_q;
        if (frame_done) begin
            state_d = pattern_t'(vga_state);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign pattern = state_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: two-stage colour pipeline behind a timing stage.
// Stage 1 computes the pattern colour; stage 2 blanks it outside the active
// area and registers the outputs. Syncs travel through the same two stages.
// Ports:
//   clk, rst               pixel clock / synchronous active-high reset
//   vga_state              requested pattern, committed on frame_done
//   pix_x, pix_y           pixel coordinate from the timing stage
//   pix_visible            coordinate lies in the active area
//   hsync_in, vsync_in     active-low syncs from the timing stage
//   frame_done             end-of-frame pulse
//   vga_r, vga_g, vga_b    registered 2-bit colour
//   hsync, vsync           registered syncs, aligned with colour
// Build option: define VGA_PATTERN_SCROLL_EN to scroll bars and checker
// horizontally by frame_cnt pixels per frame.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] vga_state,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_visible,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       frame_done,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       hsync,
    output logic       vsync
);

    // The coordinate ports are 10 bits wide; a larger active area cannot be
    // addressed, and this block marks such a configuration in the hierarchy.
    if (H_VISIBLE > 1024 || V_VISIBLE > 1024) begin : g_visible_area_too_large
    end

    pattern_t   pattern;
    logic [7:0] frame_cnt;

    vga_pattern_sel u_sel (
        .clk        (clk),
        .rst        (rst),
        .vga_state  (vga_state),
        .frame_done (frame_done),
        .pattern    (pattern),
        .frame_cnt  (frame_cnt)
    );

    logic [9:0] x_eff;

`ifdef VGA_PATTERN_SCROLL_EN
    // 10-bit wrap is intended: the scrolled image repeats every 1024 pixels.
    assign x_eff = pix_x + {2'b00, frame_cnt};
`else
    assign x_eff = pix_x;
    logic [5:0] unused_frame_cnt_lsb;
    assign unused_frame_cnt_lsb = frame_cnt[5:0];
`endif

    logic [6:0] unused_pix_y;
    assign unused_pix_y = {pix_y[9:8], pix_y[4:0]};

    logic [2:0] bar;
    logic [5:0] colour_d;

    assign bar = bar_index(x_eff);

    always_comb begin
        colour_d = BLUE;
        case (pattern)
            PAT_SOLID:    colour_d = BLUE;
            PAT_BARS:     colour_d = {{2{bar[2]}}, {2{bar[1]}}, {2{bar[0]}}};
            PAT_CHECKER:  colour_d = (x_eff[5] ^ pix_y[5]) ? WHITE : BLACK;
            PAT_GRADIENT: colour_d = {pix_x[7:6], pix_y[7:6], frame_cnt[7:6]};
            default:      colour_d = BLUE;
        endcase
    end

    logic [5:0] s1_colour;
    logic       s1_visible;
    logic       s1_hsync;
    logic       s1_vsync;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_colour  <= BLACK;
            s1_visible <= 1'b0;
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
        end else begin
            s1_colour  <= colour_d;
            s1_visible <= pix_visible;
            s1_hsync   <= hsync_in;
            s1_vsync   <= vsync_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {vga_r, vga_g, vga_b} <= BLACK;
            hsync                 <= 1'b1;
            vsync                 <= 1'b1;
        end else begin
            {vga_r, vga_g, vga_b} <= s1_visible ? s1_colour : BLACK;
            hsync                 <= s1_hsync;
            vsync                 <= s1_vsync;
        end
    end

endmodule
